phy_tx_paralelo_serie: RTL and testbench
========================================

# phy_tx_paralelo_serie

Transmit-side parallel-to-serial stage of the PHY, sitting directly upstream of the receive-side serial-to-parallel converter across the serial link. It accepts bytes on a valid/ready handshake and shifts them out MSB-first, one bit per `clk_8f` cycle. After reset it emits a mandatory preamble of comma characters (8'hBC) so the receiver can lock. Whenever no data byte is pending, it fills the link with commas.

## Interface
- `SYNC_COUNT`, default 4: number of comma characters sent after reset before data may go out. The receiver needs more than 3.
- `IDLE_CHAR`, default 8'hBC: comma/idle character used for the preamble and for idle fill.
- `clk_8f` in 1: bit clock. This is the only clock. All logic triggers on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `valid_in` in 1: a byte is offered on `data_in`.
- `data_in` in 8: byte to transmit.
- `data_ready` out 1: the one-byte holding buffer is empty, so a byte can be accepted.
- `serial_out` out 1: serial bit stream, registered, MSB first.
- `char_start` out 1: high for the one cycle in which `serial_out` carries bit 7 of a character.
- `sync_done` out 1: the preamble is complete and the stage is in RUN.

## Operation
- **Internal state**
  - 3-bit `phase` counter, 0..7. It wraps from 7 to 0.
  - 8-bit shift register.
  - 8-bit holding buffer plus a `buf_full` flag.
  - Preamble counter, wide enough for `SYNC_COUNT`.
  - 2-state FSM: SYNC and RUN.
- **Reset values (while `reset` is low)**
  - `serial_out`=0, `char_start`=0, `sync_done`=0.
  - `buf_full`=0, so `data_ready`=1.
  - `phase`=7, state=SYNC, preamble count=0, shift register=0.
- **Load edge:** any rising edge at which `phase`==7. On it:
  - `phase` becomes 0.
  - A new character is chosen and loaded.
  - `serial_out` takes the character's bit 7.
  - `char_start` is 1.
- **Other edges:** `phase` increments, the shift register shifts left, `serial_out` takes the next bit, and `char_start` is 0.
- **Character selection on a load edge**
  - SYNC: load `IDLE_CHAR` and increment the preamble count. When the count reaches `SYNC_COUNT`, the next load edge enters RUN instead. That edge is treated as a RUN load and sets `sync_done`=1.
  - RUN, `buf_full`=1: load the buffer and clear `buf_full`.
  - RUN, `buf_full`=0: load `IDLE_CHAR`.
- **Handshake**
  - `data_ready` = !`buf_full` (combinational).
  - A byte is accepted on any edge with `valid_in`=1 and `data_ready`=1. The byte is captured and `buf_full` is set.
  - Acceptance is allowed in both SYNC and RUN. In SYNC the byte waits in the buffer until RUN.
  - Draining and accepting never happen on the same edge: on a load edge with `buf_full`=1, `data_ready` was already 0.
- **Data byte equal to `IDLE_CHAR`:** it is accepted and sent unchanged. The receiver discards it, and the upper layer is responsible for not sending it.
- **Valid without ready:** if `valid_in`=1 while `data_ready`=0, nothing is captured. The source must hold the byte.
- **`sync_done`:** once set, it stays 1 until reset.

## Timing
- First load edge is the first rising edge after `reset` deasserts. Bit 7 of comma #1 is on `serial_out` after that edge.
- Preamble length is `SYNC_COUNT`×8 cycles. With the default, data can first appear 32 cycles after the first load edge.
- Latency: a byte accepted at edge k has its MSB on `serial_out` after the first load edge strictly later than k. This is 1 to 8 cycles in RUN.
- Throughput is one byte per 8 cycles. After a load edge drains the buffer, `data_ready` returns high for the remaining 7 cycles, so a source offering continuously gets zero idle characters between its bytes.
- Reset mid-character:
  - The current character is abandoned and any buffered byte is lost.
  - All outputs go to their reset values immediately (asynchronous).
  - The preamble restarts from count 0.
- `char_start` marks the character boundary. Bench and receiver-side checks use it to align parallel comparisons.

## Test plan
- **Reset then idle:** hold `reset` low 3 cycles, release, and keep `valid_in`=0 for 64 cycles.
  - `serial_out` = 8'hBC repeated 8 times.
  - `char_start` pulses every 8 cycles.
  - `sync_done` rises on the 5th load edge.
- **Single byte:** offer 8'hA5 during the preamble.
  - `data_ready` drops the cycle after acceptance.
  - The byte is held until RUN.
  - Bits 1,0,1,0,0,1,0,1 appear starting on the 5th load edge, followed by BC fill.
- **Back-to-back stream:** in RUN, offer 8'h01, 8'h02, …, 8'h10 with `valid_in` held high.
  - 16 consecutive characters appear with no BC between them.
  - Exactly one acceptance per 8 cycles.
- **Backpressure:** assert `valid_in` with 8'h3C while `buf_full`=1.
  - No capture occurs.
  - 8'h3C is captured on the first cycle after the draining load edge.
- **Reset mid-character:** pull `reset` low at `phase`=3 with the buffer full.
  - `serial_out`, `char_start` and `sync_done` clear immediately and `data_ready`=1.
  - After release, a full 4-comma preamble precedes any data.
- **Parameter and corner cases:** run with `SYNC_COUNT`=6 and send a data byte of 8'hBC.
  - 6 commas precede RUN.
  - The 8'hBC data byte is transmitted verbatim, with `sync_done` rising on the 7th load edge.

Source files
------------

// File: rtl/phy_tx_paralelo_serie.sv
// PHY transmit stage: one-byte buffered parallel-to-serial, MSB first.
// Ports: clk_8f, reset (async low), valid_in/data_in/data_ready, serial_out, char_start, sync_done.
module phy_tx_paralelo_serie #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  IDLE_CHAR  = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       data_ready,
  output logic       serial_out,
  output logic       char_start,
  output logic       sync_done
);

  localparam int CW = $clog2(SYNC_COUNT + 1);

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      phase;
  logic [7:0]      shreg;
  logic [7:0]      buf_q;
  logic            buf_full;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load;
  logic            accept;
  logic            drain;
  logic            set_done;
  logic [7:0]      char_d;

  assign load       = (phase == 3'd7);
  assign data_ready = !buf_full;
  assign accept     = valid_in && !buf_full;
  // shreg[7] is the bit on the wire, so the output is a flop
  assign serial_out = shreg[7];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    char_d   = IDLE_CHAR;
    drain    = 1'b0;
    set_done = 1'b0;
    if (load) begin
      unique case (state_q)
        SYNC: begin
          // the edge after the last comma already behaves as RUN
          if (cnt_q == CW'(SYNC_COUNT)) begin
            state_d  = RUN;
            set_done = 1'b1;
            drain    = buf_full;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: drain = buf_full;
      endcase
      if (drain) char_d = buf_q;
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q    <= SYNC;
      cnt_q      <= '0;
      phase      <= 3'd7;
      shreg      <= '0;
      char_start <= 1'b0;
      sync_done  <= 1'b0;
      buf_q      <= '0;
      buf_full   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase      <= phase + 3'd1;
      char_start <= load;
      if (load) shreg <= char_d;
      else      shreg <= {shreg[6:0], 1'b0};
      if (set_done) sync_done <= 1'b1;
      // accept needs an empty buffer, drain a full one
      if (accept) begin
        buf_q    <= data_in;
        buf_full <= 1'b1;
      end else if (drain) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_paralelo_serie.sv
// Directed bench for phy_tx_paralelo_serie.
// Default instance plus a SYNC_COUNT=6 instance.
module tb_phy_tx_paralelo_serie;

  logic clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  logic       reset, valid_in, data_ready, serial_out, char_start, sync_done;
  logic [7:0] data_in;
  logic       reset6, valid6, ready6, so6, cs6, sd6;
  logic [7:0] data6;

  phy_tx_paralelo_serie dut (
    .clk_8f(clk_8f), .reset(reset), .valid_in(valid_in),
    .data_in(data_in), .data_ready(data_ready),
    .serial_out(serial_out), .char_start(char_start),
    .sync_done(sync_done)
  );

  phy_tx_paralelo_serie #(.SYNC_COUNT(6)) dut6 (
    .clk_8f(clk_8f), .reset(reset6), .valid_in(valid6),
    .data_in(data6), .data_ready(ready6),
    .serial_out(so6), .char_start(cs6),
    .sync_done(sd6)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // character monitor for the default instance
  typedef struct packed { logic [7:0] ch; logic sd; } mchar_t;
  mchar_t     q[$];
  logic [7:0] msh;
  logic       msd;
  int         mcnt = 0;

  always @(posedge clk_8f) begin
    #1;
    if (!reset) mcnt = 0;
    else if (char_start) begin
      msh  = {7'd0, serial_out};
      msd  = sync_done;
      mcnt = 1;
    end else if (mcnt > 0) begin
      msh = {msh[6:0], serial_out};
      mcnt++;
    end
    if (mcnt == 8) begin
      q.push_back('{msh, msd});
      mcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk_8f);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_cs();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!char_start && n < 16);
    chk("wait_char_start", char_start, 1);
  endtask

  task automatic send(input logic [7:0] d, output int n);
    logic acc, got;
    valid_in = 1'b1;
    data_in  = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 32) begin
      acc = data_ready;
      tick();
      n++;
      got = acc;
    end
    valid_in = 1'b0;
    chk("accept_timeout", got, 1);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    ticks(3);
    reset = 1'b1;
    q.delete();
  endtask

  function automatic int find(input logic [7:0] c);
    for (int i = 0; i < q.size(); i++)
      if (q[i].ch == c) return i;
    return -1;
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] din;
    int         d;
    int         lat;
  } lat_t;

  vec_t       vec[16];
  lat_t       lv[5];
  logic [7:0] e2[6];
  logic       s2[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, idx, lat;
    logic [7:0] ch;

    for (int i = 0; i < 16; i++) vec[i] = '{8'(i + 1), 8'(i + 1)};
    lv[0] = '{8'h5A, 0, 7};
    lv[1] = '{8'hFF, 6, 1};
    lv[2] = '{8'h00, 7, 8};
    lv[3] = '{8'h81, 3, 4};
    lv[4] = '{8'hC3, 1, 6};
    e2 = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'hBC};
    s2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    reset6 = 1'b0; valid6 = 1'b0; data6 = 8'h00;

    // reset then idle
    ticks(3);
    chk("rst_serial_out", serial_out, 0);
    chk("rst_char_start", char_start, 0);
    chk("rst_sync_done", sync_done, 0);
    chk("rst_data_ready", data_ready, 1);
    reset = 1'b1;
    q.delete();
    ticks(64);
    chk("idle_count", q.size(), 8);
    for (int i = 0; i < q.size() && i < 8; i++) begin
      chk("idle_char", q[i].ch, 8'hBC);
      chk("idle_sync_done", q[i].sd, (i >= 4));
    end

    // single byte during preamble
    do_reset();
    ticks(2);
    send(8'hA5, n);
    chk("single_ready_low", data_ready, 0);
    ticks(17);
    chk("single_held", data_ready, 0);
    ticks(28);
    chk("single_count", q.size(), 6);
    for (int i = 0; i < q.size() && i < 6; i++) begin
      chk("single_char", q[i].ch, e2[i]);
      chk("single_sync_done", q[i].sd, s2[i]);
    end

    // back-to-back stream
    q.delete();
    for (int i = 0; i < 16; i++) begin
      send(vec[i].din, n);
      if (i >= 2) chk("stream_gap", n, 8);
    end
    ticks(24);
    idx = 0;
    while (idx < q.size() && q[idx].ch == 8'hBC) idx++;
    chk("stream_len", (q.size() >= idx + 17), 1);
    if (q.size() >= idx + 17) begin
      for (int i = 0; i < 16; i++)
        chk("stream_char", q[idx + i].ch, vec[i].exp);
      chk("stream_tail_idle", q[idx + 16].ch, 8'hBC);
    end

    // latency versus offer phase
    for (int k = 0; k < 5; k++) begin
      wait_cs();
      ticks(lv[k].d);
      send(lv[k].din, n);
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!char_start && lat < 16);
      chk("latency", lat, lv[k].lat);
      q.delete();
      ticks(7);
      chk("latency_count", q.size(), 1);
      if (q.size() > 0) chk("latency_char", q[0].ch, lv[k].din);
    end

    // backpressure
    wait_cs();
    send(8'h11, n);
    chk("bp_ready_low", data_ready, 0);
    send(8'h3C, n);
    chk("bp_accept_delay", n, 8);
    ticks(20);
    idx = find(8'h11);
    chk("bp_first_found", (idx >= 0 && idx + 1 < q.size()), 1);
    if (idx >= 0 && idx + 1 < q.size())
      chk("bp_second_char", q[idx + 1].ch, 8'h3C);

    // reset mid-character with a full buffer
    wait_cs();
    send(8'h77, n);
    ticks(2);
    chk("mid_buf_full", data_ready, 0);
    chk("mid_sync_before", sync_done, 1);
    reset = 1'b0;
    #1;
    chk("mid_serial_out", serial_out, 0);
    chk("mid_char_start", char_start, 0);
    chk("mid_sync_done", sync_done, 0);
    chk("mid_data_ready", data_ready, 1);
    ticks(2);
    reset = 1'b1;
    q.delete();
    ticks(40);
    chk("mid_count", q.size(), 5);
    for (int i = 0; i < q.size() && i < 5; i++) begin
      chk("mid_char", q[i].ch, 8'hBC);
      chk("mid_char_sync", q[i].sd, (i == 4));
    end

    // SYNC_COUNT=6 with a data byte equal to the comma
    valid6 = 1'b1;
    data6  = 8'hBC;
    reset6 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      ch = 8'h00;
      for (int b = 0; b < 8; b++) begin
        tick();
        if (b == 0) begin
          valid6 = 1'b0;
          chk("p6_char_start", cs6, 1);
          chk("p6_sync_done", sd6, (c == 6));
          chk("p6_ready", ready6, (c == 6));
        end
        ch = {ch[6:0], so6};
      end
      chk("p6_char", ch, 8'hBC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
